// File: rtl/peripheral_wb_burst_responder.sv
// Wishbone B3 slave RAM serving classic and incrementing bursts (linear, wrap4/8/16).
// Optional range checking with error termination is enabled by defining WB_RESPONDER_ERR_EN.
module peripheral_wb_burst_responder #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter logic [31:0] MEM_HIGH = 32'h00007fff
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned OFF_W = $clog2(SW);
  localparam int unsigned WORDS = (MEM_HIGH + 1) / SW;
  localparam int unsigned IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] baddr_q, baddr_d, nxt_addr, rd_addr;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW-1:0] mem_q [WORDS];
  logic          beat, ack, err, load, range_err, rd_oor;

  // Wrap bursts only advance the low log2(N) bits of the word index.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [AW-1:0] w, inc, m;
    w   = a >> OFF_W;
    inc = w + AW'(1);
    unique case (bte)
      2'b01:   m = AW'(3);
      2'b10:   m = AW'(7);
      2'b11:   m = AW'(15);
      default: m = '1;
    endcase
    w = (w & ~m) | (inc & m);
    return (w << OFF_W) | (a & AW'(SW - 1));
  endfunction

  assign nxt_addr = next_addr(baddr_q, wb_bte_i);

`ifdef WB_RESPONDER_ERR_EN
  assign range_err = baddr_q > AW'(MEM_HIGH);
  assign rd_oor    = rd_addr > AW'(MEM_HIGH);
`else
  assign range_err = 1'b0;
  assign rd_oor    = 1'b0;
  logic unused_rd;
  assign unused_rd = ^{rd_addr[AW-1:OFF_W+IDX_W], rd_addr[OFF_W-1:0]};
`endif

  always_comb begin
    state_d = state_q;
    baddr_d = baddr_q;
    dat_d   = dat_q;
    rd_addr = baddr_q;
    load    = 1'b0;
    beat    = (state_q == ACK) && wb_cyc_i && wb_stb_i;
    ack     = beat && !range_err;
    err     = beat && range_err;
    unique case (state_q)
      IDLE: if (wb_cyc_i && wb_stb_i) begin
        baddr_d = wb_adr_i;
        rd_addr = wb_adr_i;
        load    = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        if (!wb_cyc_i)      state_d = IDLE;
        else if (!wb_stb_i) state_d = HOLD;
        else if (!range_err && wb_cti_i == 3'b010) begin
          baddr_d = nxt_addr;
          rd_addr = nxt_addr;
          load    = 1'b1;
        end else            state_d = IDLE;
      end
      HOLD: begin
        if (!wb_cyc_i) state_d = IDLE;
        else if (wb_stb_i) begin
          load    = 1'b1;
          state_d = ACK;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) dat_d = rd_oor ? '0 : mem_q[rd_addr[OFF_W +: IDX_W]];
    if (err)  dat_d = '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      baddr_q <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      dat_q   <= dat_d;
    end
  end

  // RAM contents survive reset, so this process has no reset branch.
  always_ff @(posedge wb_clk_i) begin
    if (ack && wb_we_i) begin
      for (int i = 0; i < SW; i++)
        if (wb_sel_i[i]) mem_q[baddr_q[OFF_W +: IDX_W]][8*i +: 8] <= wb_dat_i[8*i +: 8];
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack;
  assign wb_err_o = err;
  assign wb_rty_o = 1'b0;
endmodule

// File: tb/tb_peripheral_wb_burst_responder.sv
// Directed self-checking bench for peripheral_wb_burst_responder.
module tb_peripheral_wb_burst_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat_i, dat_o;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err, rty;
  logic [2:0]  cti;
  logic [1:0]  bte;
  int          n_assert = 0;
  int          n_fail   = 0;

  peripheral_wb_burst_responder dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One classic access; returns ack before the edge, ack/err/data in the ack cycle, ack after.
  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic pre, output logic ak,
                         output logic er, output logic [31:0] q, output logic post);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s; cti = 3'b000; bte = 2'b00;
    #1 pre = ack;
    tick();
    ak = ack; er = err; q = dat_o;
    tick();
    post = ack;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic p, k, e, o;
    logic [31:0] q;
    classic(1'b1, a, d, s, p, k, e, q, o);
    chk("write ack", {31'b0, k}, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic p, k, e, o;
    logic [31:0] q;
    classic(1'b0, a, 32'h0, 4'h0, p, k, e, q, o);
    chk({tag, " ack"}, {31'b0, k}, 32'd1);
    chk({tag, " data"}, q, exp);
  endtask

  initial begin
    logic p, k, e, o;
    logic [31:0] q;
    int acks, low, cycles;
    rst_n = 0; adr = 0; dat_i = 0; sel = 0; we = 0; cyc = 0; stb = 0; cti = 0; bte = 0;
    #12;
    chk("reset ack", {31'b0, ack}, 32'd0);
    chk("reset err", {31'b0, err}, 32'd0);
    chk("reset dat", dat_o, 32'h0);
    chk("rty tied", {31'b0, rty}, 32'd0);
    rst_n = 1;
    tick();

    // 1: classic write then read, ack one cycle after strobe
    classic(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, p, k, e, q, o);
    chk("t1 wr ack before edge", {31'b0, p}, 32'd0);
    chk("t1 wr ack", {31'b0, k}, 32'd1);
    chk("t1 wr ack after", {31'b0, o}, 32'd0);
    classic(1'b0, 32'h100, 32'h0, 4'h0, p, k, e, q, o);
    chk("t1 rd ack before edge", {31'b0, p}, 32'd0);
    chk("t1 rd ack", {31'b0, k}, 32'd1);
    chk("t1 rd data", q, 32'hDEADBEEF);
    chk("t1 rd ack after", {31'b0, o}, 32'd0);

    // 2: byte-lane write
    wr(32'h40, 32'h11223344, 4'hF);
    wr(32'h40, 32'h0000AB00, 4'b0010);
    rd_chk("t2 sel merge", 32'h40, 32'h1122AB44);

    // 3: wrap4 read burst from 0x18
    wr(32'h10, 32'hA0A0A0A0, 4'hF);
    wr(32'h14, 32'hA1A1A1A1, 4'hF);
    wr(32'h18, 32'hA2A2A2A2, 4'hF);
    wr(32'h1C, 32'hA3A3A3A3, 4'hF);
    cyc = 1; stb = 1; we = 0; adr = 32'h18; cti = 3'b010; bte = 2'b01;
    tick();
    chk("t3 beat0 ack", {31'b0, ack}, 32'd1);
    chk("t3 beat0 dat", dat_o, 32'hA2A2A2A2);
    tick();
    chk("t3 beat1 ack", {31'b0, ack}, 32'd1);
    chk("t3 beat1 dat", dat_o, 32'hA3A3A3A3);
    tick();
    chk("t3 beat2 ack", {31'b0, ack}, 32'd1);
    chk("t3 beat2 dat", dat_o, 32'hA0A0A0A0);
    tick();
    cti = 3'b111;
    #1;
    chk("t3 beat3 ack", {31'b0, ack}, 32'd1);
    chk("t3 beat3 dat", dat_o, 32'hA1A1A1A1);
    tick();
    chk("t3 ack after burst", {31'b0, ack}, 32'd0);
    cyc = 0; stb = 0; bte = 0; cti = 0;
    tick();

    // 4: linear 8-beat write burst with a 2-cycle strobe drop after beat 3
    cyc = 1; stb = 1; we = 1; adr = 32'h200; sel = 4'hF; bte = 2'b00; cti = 3'b010; dat_i = 1;
    acks = 0; low = 0; cycles = 0;
    tick();
    while (acks < 8 && cycles < 40) begin
      stb = (low > 0) ? 1'b0 : 1'b1;
      if (low > 0) low--;
      dat_i = 32'(acks + 1);
      cti   = (acks == 7) ? 3'b111 : 3'b010;
      #1;
      if (!stb) chk("t4 ack while stb low", {31'b0, ack}, 32'd0);
      if (ack) begin
        acks++;
        if (acks == 4) low = 2;
      end
      tick();
      cycles++;
    end
    chk("t4 ack count", 32'(acks), 32'd8);
    chk("t4 ack after burst", {31'b0, ack}, 32'd0);
    cyc = 0; stb = 0; we = 0; cti = 0;
    tick();
    for (int i = 0; i < 8; i++) rd_chk("t4 readback", 32'h200 + 32'(4 * i), 32'(i + 1));

    // 5: access above MEM_HIGH
    wr(32'h0, 32'hCAFEF00D, 4'hF);
    classic(1'b0, 32'h8000, 32'h0, 4'h0, p, k, e, q, o);
`ifdef WB_RESPONDER_ERR_EN
    chk("t5 err", {31'b0, e}, 32'd1);
    chk("t5 no ack", {31'b0, k}, 32'd0);
    chk("t5 err dat", q, 32'h0);
`else
    chk("t5 alias ack", {31'b0, k}, 32'd1);
    chk("t5 no err", {31'b0, e}, 32'd0);
    chk("t5 alias dat", q, 32'hCAFEF00D);
`endif
    chk("t5 err after", {31'b0, err}, 32'd0);

    // 6: async reset during beat 2 of a write burst
    cyc = 1; stb = 1; we = 1; adr = 32'h300; sel = 4'hF; bte = 2'b00; cti = 3'b010;
    dat_i = 32'h600D0000;
    tick();
    chk("t6 beat0 ack", {31'b0, ack}, 32'd1);
    tick();
    dat_i = 32'h600D0001;
    #1 chk("t6 beat1 ack", {31'b0, ack}, 32'd1);
    tick();
    dat_i = 32'h600D0002;
    #1 chk("t6 beat2 ack", {31'b0, ack}, 32'd1);
    rst_n = 0;
    #1;
    chk("t6 ack in reset", {31'b0, ack}, 32'd0);
    chk("t6 dat in reset", dat_o, 32'h0);
    cyc = 0; stb = 0; we = 0; cti = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    rd_chk("t6 beat0 kept", 32'h300, 32'h600D0000);
    rd_chk("t6 beat1 kept", 32'h304, 32'h600D0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
